psum_accum_relu: RTL and testbench
==================================

Name: psum_accum_relu

Overview:
- Per-column partial-sum accumulator and ReLU stage. Sits between the psum memory read port and the output memory write-back.
- Consumes col-wide psum vectors, one per handshake beat, over a programmed number of kernel passes. Sums them per column in signed psum_bw arithmetic, applies ReLU, and presents one result vector through a valid/ready handshake.

Parameters:
- psum_bw, 16, width of each signed column psum (two's complement)
- col, 8, number of columns (lanes) per vector
- len_bw, 4, width of the pass-count configuration input

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- start  input  1  begin a new accumulation; sampled only in IDLE
- cfg_len  input  len_bw  number of input vectors to accumulate; latched on start; value 0 treated as 1
- in_valid  input  1  in_data holds a valid psum vector
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  col*psum_bw  psum vector; lane i at bits [i*psum_bw +: psum_bw]
- out_valid  output  1  out_data holds the finished vector
- out_ready  input  1  downstream accepts out_data
- out_data  output  col*psum_bw  ReLU'd accumulated vector, same lane packing
- busy  output  1  high in ACCUM or HOLD

Behaviour:
- Reset values: state=IDLE, acc lanes=0, pass counter=0, in_ready=0, out_valid=0, out_data=0, busy=0.
- A beat is a cycle with in_valid & in_ready. An output transfer is a cycle with out_valid & out_ready.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1: latch len = (cfg_len==0 ? 1 : cfg_len), clear acc to 0, clear counter, go to ACCUM next cycle.
- ACCUM:
  - in_ready=1 combinationally.
  - Each beat: acc[i] <= acc[i] + in_data[i] for every lane, counter += 1.
  - in_valid=0 stalls; acc and counter hold.
  - On the beat where counter == len-1:
    - out_data[i] <= relu(acc[i] + in_data[i]), where relu(x) = x<0 ? 0 : x;
    - out_valid <= 1; go to HOLD.
  - Result latency: out_valid rises the cycle after the final beat.
- HOLD:
  - in_ready=0. out_valid and out_data stable until the output transfer.
  - On transfer: out_valid <= 0, go to IDLE.
  - start is ignored outside IDLE. A start in the same cycle as the HOLD transfer is ignored; the next start is sampled one cycle later in IDLE.
- Arithmetic (default build): signed psum_bw addition, wraps modulo 2^psum_bw, no carry kept.
- len=1: the single beat goes directly to HOLD with relu(in_data).
- Max len = 2^len_bw - 1. The counter never wraps because the FSM leaves ACCUM at len-1.
- Reset during ACCUM or HOLD aborts the operation: the pending result is discarded and out_valid falls on that edge.
- out_data holds the last result after the transfer, until the next completion or reset.

Optional Feature:
- Macro: PSUM_ACCUM_SAT_EN.
- Defined:
  - each lane add saturates to [-2^(psum_bw-1), 2^(psum_bw-1)-1];
  - ReLU is applied after saturation;
  - an extra output port sat_flag (1 bit) is registered together with out_valid. It is high if any lane saturated on any beat of the operation, and is cleared on start and on reset.
- Undefined: wrap-around arithmetic and no sat_flag port.

Test Plan:
- Reset then start, cfg_len=3, three beats with all lanes = 5, 7, -2 -> out_valid one cycle after beat 3, all lanes = 10, in_ready=0 in HOLD.
- cfg_len=2, lane0: 3 then -10; lane1: 4 then 4 -> lane0=0 (ReLU), lane1=8.
- cfg_len=4 with in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats counted; result equals the sum of accepted beats only; out_valid rises after the 7th cycle.
- HOLD with out_ready=0 for 5 cycles, then 1 -> out_data stable for all 5 cycles; transfer on 6th; start asserted in the transfer cycle ignored; start one cycle later accepted.
- cfg_len=0, one beat lanes=-1 and 9 -> treated as len 1; outputs 0 and 9.
- Lanes 32767 + 1 -> without macro 0 after ReLU (wrapped -32768); with PSUM_ACCUM_SAT_EN 32767 and sat_flag=1.
- Mid-ACCUM reset after 2 of 3 beats -> next cycle state IDLE, out_valid=0, in_ready=0, busy=0; a new run of len 1 with value 6 yields 6.

Source files
------------

// File: rtl/psum_accum_relu.sv
// Per-column partial-sum accumulator with ReLU on the finished vector.
// Optional build macro PSUM_ACCUM_SAT_EN: saturating lane adds plus a sticky sat_flag output.
module psum_accum_relu #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned len_bw  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [len_bw-1:0]      cfg_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [col*psum_bw-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef PSUM_ACCUM_SAT_EN
    output logic                   sat_flag,
`endif
    output logic [col*psum_bw-1:0] out_data,
    output logic                   busy
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    localparam logic [len_bw-1:0] LenOne = len_bw'(1);

    state_e                 state_q, state_d;
    logic [col*psum_bw-1:0] acc_q, acc_d;
    logic [col*psum_bw-1:0] out_data_q, out_data_d;
    logic [len_bw-1:0]      cnt_q, cnt_d;
    logic [len_bw-1:0]      len_q, len_d;
    logic                   out_valid_q, out_valid_d;

    logic [col*psum_bw-1:0] sum_vec, relu_vec;
    logic [psum_bw-1:0]     lane_a, lane_b, lane_sum;

`ifdef PSUM_ACCUM_SAT_EN
    localparam logic [psum_bw-1:0] SatMax = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] SatMin = {1'b1, {(psum_bw-1){1'b0}}};

    logic [psum_bw:0] lane_ext;
    logic [col-1:0]   lane_ovf;
    logic             sat_q, sat_d;
`endif

    // Per-lane add of the incoming beat onto the running sum, then ReLU.
    always_comb begin
        sum_vec  = '0;
        relu_vec = '0;
        lane_a   = '0;
        lane_b   = '0;
        lane_sum = '0;
`ifdef PSUM_ACCUM_SAT_EN
        lane_ext = '0;
        lane_ovf = '0;
`endif
        for (int i = 0; i < int'(col); i++) begin
            lane_a = acc_q[i*psum_bw +: psum_bw];
            lane_b = in_data[i*psum_bw +: psum_bw];
`ifdef PSUM_ACCUM_SAT_EN
            lane_ext    = {lane_a[psum_bw-1], lane_a} + {lane_b[psum_bw-1], lane_b};
            // Signed overflow shows up as the two top bits of the extended sum disagreeing.
            lane_ovf[i] = lane_ext[psum_bw] ^ lane_ext[psum_bw-1];
            lane_sum    = lane_ext[psum_bw-1:0];
            if (lane_ovf[i]) begin
                lane_sum = lane_ext[psum_bw] ? SatMin : SatMax;
            end
`else
            lane_sum = lane_a + lane_b;
`endif
            sum_vec[i*psum_bw +: psum_bw]  = lane_sum;
            relu_vec[i*psum_bw +: psum_bw] = lane_sum[psum_bw-1] ? '0 : lane_sum;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef PSUM_ACCUM_SAT_EN
        sat_d       = sat_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d = cfg_len;
                    if (cfg_len == '0) begin
                        len_d = LenOne;
                    end
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef PSUM_ACCUM_SAT_EN
                    sat_d   = 1'b0;
`endif
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (in_valid) begin
                    acc_d = sum_vec;
                    cnt_d = cnt_q + LenOne;
`ifdef PSUM_ACCUM_SAT_EN
                    sat_d = sat_q | (|lane_ovf);
`endif
                    if (cnt_q == len_q - LenOne) begin
                        out_data_d  = relu_vec;
                        out_valid_d = 1'b1;
                        state_d     = StHold;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef PSUM_ACCUM_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef PSUM_ACCUM_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign in_ready  = (state_q == StAccum);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef PSUM_ACCUM_SAT_EN
    assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_psum_accum_relu.sv
// Randomized self-checking bench for psum_accum_relu against an integer-arithmetic model.
// Honours PSUM_ACCUM_SAT_EN when the build defines it.
module tb_psum_accum_relu;

    localparam int COL = 8;
    localparam int W   = 16;
    localparam int LB  = 4;

    typedef int vec_t [COL];

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [LB-1:0]    cfg_len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [COL*W-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [COL*W-1:0] out_data;
    logic             busy;
`ifdef PSUM_ACCUM_SAT_EN
    logic             sat_flag;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t             beats_q[$];
    logic [COL*W-1:0] exp_data;
    logic             exp_sat;

    psum_accum_relu #(
        .psum_bw (W),
        .col     (COL),
        .len_bw  (LB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PSUM_ACCUM_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: per-lane integer sum over accepted beats, wrapped or clamped each beat, then ReLU.
    function automatic void model();
        longint s;
`ifndef PSUM_ACCUM_SAT_EN
        logic signed [W-1:0] t;
`endif
        exp_data = '0;
        exp_sat  = 1'b0;
        for (int i = 0; i < COL; i++) begin
            s = 0;
            foreach (beats_q[k]) begin
                s = s + longint'(beats_q[k][i]);
`ifdef PSUM_ACCUM_SAT_EN
                if (s > 32767) begin
                    s = 32767;
                    exp_sat = 1'b1;
                end else if (s < -32768) begin
                    s = -32768;
                    exp_sat = 1'b1;
                end
`else
                t = s[W-1:0];
                s = longint'(t);
`endif
            end
            if (s < 0) s = 0;
            exp_data[i*W +: W] = s[W-1:0];
        end
    endfunction

    function automatic void rand_vec(output vec_t v);
        for (int i = 0; i < COL; i++) v[i] = int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic void fill_vec(output vec_t v, input int val);
        for (int i = 0; i < COL; i++) v[i] = val;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        beats_q.delete();
    endtask

    task automatic do_start(input int len);
        cfg_len = LB'(len);
        start   = 1'b1;
        tick();
        start = 1'b0;
        beats_q.delete();
    endtask

    task automatic drive(input vec_t v, input bit valid);
        for (int i = 0; i < COL; i++) in_data[i*W +: W] = v[i][W-1:0];
        in_valid = valid;
        if (valid) beats_q.push_back(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/vld/busy=%b want 000", {in_ready, out_valid, busy});
        end
        n_cmp++;
        if (out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", out_data);
        end
    endtask

    task automatic test_basic();
        vec_t v;
        do_start(3);
        n_cmp++;
        if ({in_ready, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL basic_accum_ctrl: got rdy/busy=%b want 11", {in_ready, busy});
        end
        fill_vec(v, 5);  drive(v, 1'b1);
        fill_vec(v, 7);  drive(v, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid: got %b want 0", out_valid);
        end
        fill_vec(v, -2); drive(v, 1'b1);
        model();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_hold_ctrl: got vld/rdy=%b want 10", {out_valid, in_ready});
        end
        n_cmp++;
        if (out_data !== {COL{16'd10}} || out_data !== exp_data) begin
            n_fail++;
            $display("FAIL basic_data: got %h want %h", out_data, {COL{16'd10}});
        end
        take_out();
        n_cmp++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_after_xfer: got vld/busy=%b want 00", {out_valid, busy});
        end
    endtask

    task automatic test_relu();
        vec_t v;
        do_start(2);
        rand_vec(v); v[0] = 3;   v[1] = 4; drive(v, 1'b1);
        rand_vec(v); v[0] = -10; v[1] = 4; drive(v, 1'b1);
        model();
        n_cmp++;
        if (out_data[W-1:0] !== 16'd0 || out_data[2*W-1:W] !== 16'd8) begin
            n_fail++;
            $display("FAIL relu_lanes01: got %h %h want 0000 0008", out_data[W-1:0], out_data[2*W-1:W]);
        end
        n_cmp++;
        if (out_data !== exp_data) begin
            n_fail++;
            $display("FAIL relu_data: got %h want %h", out_data, exp_data);
        end
        take_out();
    endtask

    task automatic test_stall();
        vec_t v;
        bit   pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        do_start(4);
        for (int c = 0; c < 7; c++) begin
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got rdy/vld=%b%b want 10", c, in_ready, out_valid);
            end
            rand_vec(v);
            drive(v, pat[c]);
        end
        model();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== exp_data) begin
            n_fail++;
            $display("FAIL stall_result: got vld=%b %h want vld=1 %h", out_valid, out_data, exp_data);
        end
        take_out();
    endtask

    task automatic test_hold();
        vec_t v;
        do_start(1);
        rand_vec(v);
        drive(v, 1'b1);
        model();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_data) begin
                n_fail++;
                $display("FAIL hold_stable%0d: got vld=%b %h want vld=1 %h", c, out_valid, out_data, exp_data);
            end
        end
        out_ready = 1'b1;
        start     = 1'b1;
        cfg_len   = LB'(1);
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        n_cmp++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL hold_start_ignored: got vld/busy/rdy=%b want 000", {out_valid, busy, in_ready});
        end
        n_cmp++;
        if (out_data !== exp_data) begin
            n_fail++;
            $display("FAIL hold_data_kept: got %h want %h", out_data, exp_data);
        end
        do_start(1);
        n_cmp++;
        if ({busy, in_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL hold_restart: got busy/rdy=%b want 11", {busy, in_ready});
        end
        rand_vec(v);
        drive(v, 1'b1);
        model();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== exp_data) begin
            n_fail++;
            $display("FAIL hold_second: got vld=%b %h want vld=1 %h", out_valid, out_data, exp_data);
        end
        take_out();
    endtask

    task automatic test_len_zero();
        vec_t v;
        do_start(0);
        rand_vec(v); v[0] = -1; v[1] = 9;
        drive(v, 1'b1);
        model();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data[W-1:0] !== 16'd0 || out_data[2*W-1:W] !== 16'd9) begin
            n_fail++;
            $display("FAIL len0: got vld=%b %h %h want vld=1 0000 0009",
                     out_valid, out_data[W-1:0], out_data[2*W-1:W]);
        end
        take_out();
    endtask

    task automatic test_overflow();
        vec_t v;
        do_start(2);
        fill_vec(v, 32767); drive(v, 1'b1);
        fill_vec(v, 1);     drive(v, 1'b1);
        model();
`ifdef PSUM_ACCUM_SAT_EN
        n_cmp++;
        if (out_data !== {COL{16'h7fff}} || sat_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sat: got %h sat=%b want %h sat=1", out_data, sat_flag, {COL{16'h7fff}});
        end
`else
        n_cmp++;
        if (out_data !== '0) begin
            n_fail++;
            $display("FAIL ovf_wrap: got %h want 0", out_data);
        end
`endif
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== exp_data) begin
            n_fail++;
            $display("FAIL ovf_model: got vld=%b %h want vld=1 %h", out_valid, out_data, exp_data);
        end
        take_out();
    endtask

    task automatic test_mid_reset();
        vec_t v;
        do_start(3);
        rand_vec(v); drive(v, 1'b1);
        rand_vec(v); drive(v, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({busy, in_ready, out_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_ctrl: got busy/rdy/vld=%b want 000", {busy, in_ready, out_valid});
        end
        do_start(1);
        fill_vec(v, 6);
        drive(v, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== {COL{16'd6}}) begin
            n_fail++;
            $display("FAIL midrst_rerun: got vld=%b %h want vld=1 %h", out_valid, out_data, {COL{16'd6}});
        end
`ifdef PSUM_ACCUM_SAT_EN
        n_cmp++;
        if (sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_sat: got %b want 0", sat_flag);
        end
`endif
        take_out();
    endtask

    task automatic test_random();
        vec_t v;
        int   len, eff, sent, guard;
        for (int op = 0; op < 25; op++) begin
            len = int'($urandom_range(0, 15));
            eff = (len == 0) ? 1 : len;
            do_start(len);
            sent  = 0;
            guard = 0;
            while (sent < eff && guard < 200) begin
                rand_vec(v);
                if ($urandom_range(0, 3) != 0) begin
                    drive(v, 1'b1);
                    sent++;
                end else begin
                    drive(v, 1'b0);
                end
                guard++;
            end
            model();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_data) begin
                n_fail++;
                $display("FAIL rand_op%0d len=%0d: got vld=%b %h want vld=1 %h",
                         op, len, out_valid, out_data, exp_data);
            end
`ifdef PSUM_ACCUM_SAT_EN
            n_cmp++;
            if (sat_flag !== exp_sat) begin
                n_fail++;
                $display("FAIL rand_sat%0d: got %b want %b", op, sat_flag, exp_sat);
            end
`endif
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
            take_out();
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_xfer%0d: got vld/busy=%b%b want 00", op, out_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_stall();
        test_hold();
        test_len_zero();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
